// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and baud helper
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam int UartDataBits = 8;
  localparam int UartStopBits = 1;

  // Truncating division; shared with the receiver so both sides agree on the bit period.
  function automatic int uart_clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter, tick on the last cycle of each bit
module uart_baud_counter #(
  parameter int ClksPerBit = 217
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CntW = $clog2(ClksPerBit);

  logic [CntW-1:0] count_q;

  assign tick_o = (count_q == CntW'(ClksPerBit - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      count_q <= '0;
    end else if (tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART transmitter with a one-byte holding buffer
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int ClkFreqHz = 25_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int ClksPerBit = uart_clks_per_bit(ClkFreqHz, BaudRate);

  if (ClksPerBit < 2) begin : g_bad_baud
    $error("uart_tx_byte: ClksPerBit must be at least 2");
  end

  uart_tx_state_e state_q, state_d;
  logic [7:0]     shifter_q, shifter_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     buf_q, buf_d;
  logic           buf_full_q, buf_full_d;
  logic           tx_q, tx_d;
  logic           tick;
  logic           handshake;

  assign ready_o   = !buf_full_q;
  assign handshake = valid_i && ready_o;
  assign busy_o    = (state_q != IDLE) || buf_full_q;
  assign tx_o      = tx_q;

  // Held at zero while idle so the start bit always gets a full period.
  uart_baud_counter #(
    .ClksPerBit(ClksPerBit)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(state_q == IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    shifter_d  = shifter_q;
    bit_cnt_d  = bit_cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;

    // A byte arriving on the final stop cycle bypasses the buffer.
    if (handshake && (state_q != IDLE) && !((state_q == STOP) && tick)) begin
      buf_d      = data_i;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          shifter_d = data_i;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shifter_d = {1'b0, shifter_q[7:1]};
          if (bit_cnt_q == 3'(UartDataBits - 1)) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (buf_full_q) begin
            shifter_d  = buf_q;
            buf_full_d = 1'b0;
            state_d    = START;
          end else if (handshake) begin
            shifter_d = data_i;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered from the next state so the start bit shows the cycle after acceptance.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shifter_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shifter_q  <= '0;
      bit_cnt_q  <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shifter_q  <= shifter_d;
      bit_cnt_q  <= bit_cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb/tb_uart_tx_byte.sv - directed self-checking bench for uart_tx_byte at 4 clocks per bit
module tb_uart_tx_byte;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [159:0] tx_cap;
  logic [159:0] rdy_cap;
  logic [159:0] rdy_exp;
  logic         any_low;

  always #5 clk = ~clk;

  uart_tx_byte #(
    .ClkFreqHz(400),
    .BaudRate (100)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (data),
    .valid_i(valid),
    .ready_o(ready),
    .tx_o   (tx),
    .busy_o (busy)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stretch a 10-bit frame (bit 0 = start bit, sent first) to 4 samples per bit.
  function automatic logic [39:0] expand(input logic [9:0] f);
    logic [39:0] r;
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    valid = 1'b1;
    data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);

    valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_frame_after_reset_tx", tx, 1);
    chk("no_frame_after_reset_busy", busy, 0);

    // Single byte 0x55
    data  = 8'h55;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("busy_in_frame", busy, 1);
    for (int j = 0; j < 40; j++) begin
      tx_cap[j] = tx;
      @(negedge clk);
    end
    chk("frame_55", tx_cap[39:0], expand(10'h2AA));
    chk("busy_after_55", busy, 0);
    chk("idle_tx_after_55", tx, 1);

    // Back-to-back 0x00, 0xFF, then 0xA5 offered while full, then 0x3C on the last stop cycle
    data  = 8'h00;
    valid = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 160; j++) begin
      tx_cap[j]  = tx;
      rdy_cap[j] = ready;
      if (j == 0) data = 8'hFF;
      if (j == 1) valid = 1'b0;
      if (j >= 1 && j <= 18) data = (j % 2 == 1) ? 8'h3C : 8'hC3;
      if (j == 19) begin
        valid = 1'b1;
        data  = 8'hA5;
      end
      if (j == 41) begin
        valid = 1'b0;
        data  = 8'h5A;
      end
      if (j > 41 && j < 80) data = ~data;
      if (j == 119) begin
        valid = 1'b1;
        data  = 8'h3C;
      end
      if (j == 120) valid = 1'b0;
      @(negedge clk);
    end
    rdy_exp = '1;
    for (int j = 1; j < 40; j++) rdy_exp[j] = 1'b0;
    for (int j = 41; j < 80; j++) rdy_exp[j] = 1'b0;
    chk("frame_00", tx_cap[39:0], expand(10'h200));
    chk("frame_ff", tx_cap[79:40], expand(10'h3FE));
    chk("frame_a5", tx_cap[119:80], expand(10'h34A));
    chk("frame_3c_bypass", tx_cap[159:120], expand(10'h278));
    chk("ready_profile", rdy_cap, rdy_exp);
    chk("busy_after_burst", busy, 0);
    chk("ready_after_burst", ready, 1);

    // Reset during data bit 3 of 0x0F with 0x81 buffered
    data  = 8'h0F;
    valid = 1'b1;
    @(negedge clk);
    data = 8'h81;
    @(negedge clk);
    valid = 1'b0;
    chk("buffer_full_before_reset", ready, 0);
    repeat (15) @(negedge clk);
    chk("bit3_of_0f", tx, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_tx", tx, 1);
    chk("midreset_ready", ready, 1);
    chk("midreset_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("buffer_discarded", busy, 0);

    data  = 8'h0F;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tx_cap[j] = tx;
      @(negedge clk);
    end
    chk("frame_0f_clean", tx_cap[39:0], expand(10'h21E));
    any_low = 1'b0;
    for (int j = 0; j < 44; j++) begin
      any_low = any_low | !tx;
      @(negedge clk);
    end
    chk("no_stale_byte", any_low, 0);
    chk("busy_final", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
